// File: rtl/spn_hash_counter.sv
// Counting-bloom-filter primitive pair: a combinational substitution-permutation
// hash with one-hot decode, and an independent up/down counter with wrap flag.
module spn_hash_counter #(
  parameter int          InpWidth   = 32,
  parameter int          HashWidth  = 4,
  parameter int          NoRounds   = 1,
  parameter logic [31:0] PermuteKey = 32'd299034753,
  parameter logic [31:0] XorKey     = 32'd4094834,
  parameter int          CntWidth   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [InpWidth-1:0]       data_i,
  output logic [HashWidth-1:0]      hash_o,
  output logic [(2**HashWidth)-1:0] hash_onehot_o,
  input  logic                      clear_i,
  input  logic                      en_i,
  input  logic                      load_i,
  input  logic                      down_i,
  input  logic [CntWidth-1:0]       d_i,
  output logic [CntWidth-1:0]       q_o,
  output logic                      overflow_o
);

  localparam int MaskRows  = (NoRounds > 0) ? NoRounds : 1;
  localparam int NumChunks = (InpWidth + HashWidth - 1) / HashWidth;
  localparam int PadWidth  = NumChunks * HashWidth;
  localparam int OneHotW   = 2 ** HashWidth;

  localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};

  if (InpWidth <= HashWidth) begin : g_bad_width
    $fatal(1, "spn_hash_counter: InpWidth must be greater than HashWidth");
  end

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'd1103515245 + 32'd12345;
  endfunction

  // Fisher-Yates shuffle driven by the LCG; each entry is a 32-bit source index.
  function automatic logic [InpWidth*32-1:0] gen_perm();
    logic [InpWidth*32-1:0] p;
    logic [31:0]            s;
    logic [31:0]            j;
    logic [31:0]            tmp;
    for (int k = 0; k < InpWidth; k++) begin
      p[k*32 +: 32] = 32'(k);
    end
    s = PermuteKey;
    for (int i = InpWidth - 1; i >= 1; i--) begin
      s   = lcg(s);
      j   = {16'd0, s[31:16]} % 32'(i + 1);
      tmp = p[i*32 +: 32];
      p[i*32 +: 32] = p[j*32 +: 32];
      p[j*32 +: 32] = tmp;
    end
    return p;
  endfunction

  function automatic logic [MaskRows*InpWidth-1:0] gen_masks();
    logic [MaskRows*InpWidth-1:0] m;
    logic [31:0]                  s;
    m = {(MaskRows*InpWidth){1'b0}};
    s = XorKey;
    for (int r = 0; r < NoRounds; r++) begin
      for (int i = 0; i < InpWidth; i++) begin
        s = lcg(s);
        m[r*InpWidth + i] = s[31];
      end
    end
    return m;
  endfunction

  localparam logic [InpWidth*32-1:0]       Perm  = gen_perm();
  localparam logic [MaskRows*InpWidth-1:0] Masks = gen_masks();

  logic [NoRounds:0][InpWidth-1:0] stage_s;
  logic [PadWidth-1:0]             padded_s;
  logic [HashWidth-1:0]            hash_s;

  assign stage_s[0] = data_i;

  for (genvar r = 0; r < NoRounds; r++) begin : g_round
    logic [InpWidth-1:0] perm_s;
    logic [InpWidth-1:0] mix_s;
    logic [InpWidth-1:0] sub_s;
    for (genvar i = 0; i < InpWidth; i++) begin : g_bit
      localparam int Src = int'(Perm[i*32 +: 32]);
      assign perm_s[i] = stage_s[r][Src];
      assign sub_s[i]  = mix_s[i] ^ (~mix_s[(i+1)%InpWidth] & mix_s[(i+2)%InpWidth]);
    end
    assign mix_s          = perm_s ^ Masks[r*InpWidth +: InpWidth];
    assign stage_s[r+1]   = sub_s;
  end

  assign padded_s = PadWidth'(stage_s[NoRounds]);

  // XOR-fold the zero-padded round output down to the hash index.
  always_comb begin
    hash_s = {HashWidth{1'b0}};
    for (int c = 0; c < NumChunks; c++) begin
      hash_s = hash_s ^ padded_s[c*HashWidth +: HashWidth];
    end
  end

  assign hash_o        = hash_s;
  assign hash_onehot_o = {{(OneHotW-1){1'b0}}, 1'b1} << hash_s;

  logic [CntWidth-1:0] q_r;
  logic [CntWidth-1:0] q_nxt_s;

  // Counter next value: clear beats load beats counting.
  always_comb begin
    q_nxt_s = q_r;
    if (clear_i) begin
      q_nxt_s = CntZero;
    end else if (load_i) begin
      q_nxt_s = d_i;
    end else if (en_i && !down_i) begin
      q_nxt_s = q_r + CntOne;
    end else if (en_i && down_i) begin
      q_nxt_s = q_r - CntOne;
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Counter state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_r <= CntZero;
    end else begin
      q_r <= q_nxt_s;
    end
  end

  assign q_o = q_r;

  // Flags the wrap the coming edge will perform; reset, clear and load all pre-empt it.
  assign overflow_o = ~rst_i & en_i & ~clear_i & ~load_i &
                      ((~down_i & (q_r == CntMax)) | (down_i & (q_r == CntZero)));

endmodule

// File: tb/tb_spn_hash_counter.sv
// Self-checking bench for spn_hash_counter: hash against an independent model,
// small fold-only instance, and a table of counter vectors with a scoreboard.
module tb_spn_hash_counter;

  localparam int          InpW   = 32;
  localparam int          HashW  = 4;
  localparam int          Rounds = 1;
  localparam int          CntW   = 4;
  localparam logic [31:0] PKey   = 32'd299034753;
  localparam logic [31:0] XKey   = 32'd4094834;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [InpW-1:0]   data = '0;
  logic [HashW-1:0]  hash;
  logic [15:0]       onehot;
  logic              clear = 1'b0, en = 1'b0, load = 1'b0, down = 1'b0;
  logic [CntW-1:0]   d = '0;
  logic [CntW-1:0]   q;
  logic              ovf;

  logic [7:0]        s_data = '0;
  logic [3:0]        s_hash;
  logic [15:0]       s_onehot;
  logic              s_clear = 1'b0, s_en = 1'b0, s_load = 1'b0, s_down = 1'b0;
  logic [3:0]        s_d = '0;
  logic [3:0]        s_q;
  logic              s_ovf;

  spn_hash_counter u_dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .hash_o(hash), .hash_onehot_o(onehot),
    .clear_i(clear), .en_i(en), .load_i(load), .down_i(down), .d_i(d),
    .q_o(q), .overflow_o(ovf)
  );

  spn_hash_counter #(.InpWidth(8), .HashWidth(4), .NoRounds(0)) u_small (
    .clk_i(clk), .rst_i(rst), .data_i(s_data), .hash_o(s_hash), .hash_onehot_o(s_onehot),
    .clear_i(s_clear), .en_i(s_en), .load_i(s_load), .down_i(s_down), .d_i(s_d),
    .q_o(s_q), .overflow_o(s_ovf)
  );

  int checks = 0;
  int errors = 0;

  int              perm_m [InpW];
  logic [InpW-1:0] mask_m [Rounds];

  typedef struct {
    string      name;
    logic       rst, clear, en, load, down;
    logic [3:0] d;
    logic       exp_ovf;
    logic [3:0] exp_q;
  } cnt_vec_t;

  cnt_vec_t        vecs[$];
  logic [HashW-1:0] hash_sb[$];
  logic [3:0]       q_sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] next_seed(input logic [31:0] s);
    return s * 32'd1103515245 + 32'd12345;
  endfunction

  task automatic build_model();
    logic [31:0] s;
    int j, t;
    for (int k = 0; k < InpW; k++) perm_m[k] = k;
    s = PKey;
    for (int i = InpW - 1; i >= 1; i--) begin
      s = next_seed(s);
      j = int'(s[31:16]) % (i + 1);
      t = perm_m[i]; perm_m[i] = perm_m[j]; perm_m[j] = t;
    end
    s = XKey;
    for (int r = 0; r < Rounds; r++) begin
      for (int i = 0; i < InpW; i++) begin
        s = next_seed(s);
        mask_m[r][i] = s[31];
      end
    end
  endtask

  function automatic logic [HashW-1:0] model_hash(input logic [InpW-1:0] din);
    logic [InpW-1:0]  x, p, y;
    logic [HashW-1:0] h;
    x = din;
    for (int r = 0; r < Rounds; r++) begin
      for (int i = 0; i < InpW; i++) p[i] = x[perm_m[i]];
      y = p ^ mask_m[r];
      for (int i = 0; i < InpW; i++) x[i] = y[i] ^ (~y[(i+1)%InpW] & y[(i+2)%InpW]);
    end
    h = '0;
    for (int c = 0; c < InpW / HashW; c++) h = h ^ x[c*HashW +: HashW];
    return h;
  endfunction

  task automatic add(input string name, input logic r, input logic c, input logic e,
                     input logic l, input logic dn, input logic [3:0] dv,
                     input logic eo, input logic [3:0] eq);
    cnt_vec_t v;
    v.name = name; v.rst = r; v.clear = c; v.en = e; v.load = l; v.down = dn;
    v.d = dv; v.exp_ovf = eo; v.exp_q = eq;
    vecs.push_back(v);
  endtask

  task automatic hash_probe(input logic [InpW-1:0] v, input string name);
    logic [HashW-1:0] e;
    logic [15:0]      eoh;
    data = v;
    hash_sb.push_back(model_hash(v));
    #1;
    e   = hash_sb.pop_front();
    eoh = 16'd1 << e;
    check({name, "_hash"}, 64'(hash), 64'(e));
    check({name, "_onehot"}, 64'(onehot), 64'(eoh));
    check({name, "_popcount"}, 64'($countones(onehot)), 64'd1);
  endtask

  initial begin
    // Counter vector table: reset, full up-count, wraps, load/clear priority, reset mid-count.
    add("reset_en", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++)
      add("up16", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, (i == 15), 4'((i + 1) % 16));
    add("down_wrap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 4'hF);
    add("down_15",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'hE);
    add("load_15",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 4'hF);
    add("load_en",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h9, 1'b0, 4'h9);
    add("clr_load",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 4'h0);
    add("clr_down0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
    add("hold",      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 4'h0);
    for (int i = 1; i <= 7; i++)
      add("up_to7", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'(i));
    add("rst_at7",   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    add("load_15b",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 4'hF);
    add("rst_at15",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    add("hold_end",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

    build_model();

    // Fold-only instance, hand-computed vectors.
    s_data = 8'hA5; #1;
    check("small_A5_hash", 64'(s_hash), 64'h0F);
    check("small_A5_onehot", 64'(s_onehot), 64'h8000);
    s_data = 8'h12; #1;
    check("small_12_hash", 64'(s_hash), 64'h03);
    check("small_12_onehot", 64'(s_onehot), 64'h0008);

    // Determinism: same input revisited after a different one.
    hash_probe(32'hDEADBEEF, "repeat_a");
    hash_probe(32'h00000000, "zero");
    hash_probe(32'hDEADBEEF, "repeat_b");
    hash_probe(32'hFFFFFFFF, "ones");

    for (int n = 0; n < 10000; n++) hash_probe($urandom, "rand");

    // Apply counter table: inputs at negedge, overflow mid-low-phase, q after posedge.
    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst; clear = vecs[k].clear; en = vecs[k].en;
      load = vecs[k].load; down = vecs[k].down; d = vecs[k].d;
      q_sb.push_back(vecs[k].exp_q);
      #2;
      check({vecs[k].name, "_ovf"}, 64'(ovf), 64'(vecs[k].exp_ovf));
      @(posedge clk);
      #1;
      check({vecs[k].name, "_q"}, 64'(q), 64'(q_sb.pop_front()));
    end

    rst = 1'b0; clear = 1'b0; en = 1'b0; load = 1'b0; down = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
